// File: rtl/jt49_nch_pkg.sv
// Shared constants for the jt49_nch sound block: register map, envelope shape bits
// and the log-to-linear volume table.
package jt49_nch_pkg;

  // Per-channel register bases: tone period of channel k at 2k / 2k+1, volume at base+k.
  localparam logic [4:0] ADDR_TONE_BASE = 5'h00;
  localparam logic [4:0] ADDR_VOL_BASE  = 5'h10;

  typedef enum logic [4:0] {
    RegNoisePer = 5'h18,
    RegToneDis  = 5'h19,
    RegNoiseDis = 5'h1A,
    RegEnvLo    = 5'h1B,
    RegEnvHi    = 5'h1C,
    RegEnvShape = 5'h1D
  } jt49_reg_e;

  // Envelope shape bit positions.
  localparam int unsigned ENV_CONT = 3;
  localparam int unsigned ENV_ATT  = 2;
  localparam int unsigned ENV_ALT  = 1;
  localparam int unsigned ENV_HOLD = 0;

  function automatic logic [7:0] log2lin(input logic [4:0] idx);
    logic [7:0] lin;
    case (idx)
      5'd0:    lin = 8'd0;
      5'd1:    lin = 8'd1;
      5'd2:    lin = 8'd1;
      5'd3:    lin = 8'd1;
      5'd4:    lin = 8'd2;
      5'd5:    lin = 8'd2;
      5'd6:    lin = 8'd3;
      5'd7:    lin = 8'd3;
      5'd8:    lin = 8'd4;
      5'd9:    lin = 8'd5;
      5'd10:   lin = 8'd6;
      5'd11:   lin = 8'd7;
      5'd12:   lin = 8'd9;
      5'd13:   lin = 8'd11;
      5'd14:   lin = 8'd13;
      5'd15:   lin = 8'd15;
      5'd16:   lin = 8'd18;
      5'd17:   lin = 8'd22;
      5'd18:   lin = 8'd26;
      5'd19:   lin = 8'd31;
      5'd20:   lin = 8'd37;
      5'd21:   lin = 8'd45;
      5'd22:   lin = 8'd53;
      5'd23:   lin = 8'd63;
      5'd24:   lin = 8'd75;
      5'd25:   lin = 8'd90;
      5'd26:   lin = 8'd107;
      5'd27:   lin = 8'd127;
      5'd28:   lin = 8'd151;
      5'd29:   lin = 8'd180;
      5'd30:   lin = 8'd214;
      default: lin = 8'd255;
    endcase
    return lin;
  endfunction

endpackage

// File: rtl/jt49_nch_eg.sv
// Envelope generator: 16-bit period counter plus the 16-step AY shape sequencer
// (continue / attack / alternate / hold).
module jt49_nch_eg
  import jt49_nch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        tick,
  input  logic [15:0] per,
  input  logic [3:0]  shape,
  input  logic        restart,
  output logic [3:0]  env
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic [15:0] per_eff;
  logic [3:0]  step_q;
  logic        hold_q;
  logic        inv_q;
  logic        step_en;

  assign per_eff = (per == 16'd0) ? 16'd1 : per;
  assign cnt_inc = cnt_q + 16'd1;
  assign step_en = cnt_inc >= per_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      step_q <= '0;
      hold_q <= 1'b0;
      inv_q  <= 1'b0;
    end else if (cen) begin
      if (restart) begin
        cnt_q  <= '0;
        step_q <= '0;
        hold_q <= 1'b0;
        inv_q  <= 1'b0;
      end else if (tick) begin
        cnt_q <= step_en ? 16'd0 : cnt_inc;
        if (step_en && !hold_q) begin
          if (step_q != 4'hF) begin
            step_q <= step_q + 4'd1;
          end else if (!shape[ENV_CONT]) begin
            // One-shot shapes always settle at level 0.
            hold_q <= 1'b1;
            inv_q  <= shape[ENV_ATT];
          end else if (shape[ENV_HOLD]) begin
            hold_q <= 1'b1;
            if (shape[ENV_ALT]) inv_q <= ~inv_q;
          end else begin
            step_q <= 4'd0;
            if (shape[ENV_ALT]) inv_q <= ~inv_q;
          end
        end
      end
    end
  end

  assign env = (shape[ENV_ATT] ^ inv_q) ? step_q : ~step_q;

endmodule

// File: rtl/jt49_nch.sv
// AY-style tone/noise/envelope sound block with NCH tone channels.
// Optional JT49_NCH_CHOUT_EN: drive ch_out with per-channel linear levels.
module jt49_nch
  import jt49_nch_pkg::*;
#(
  parameter int unsigned NCH = 3,
  parameter int unsigned SW  = 8 + $clog2(NCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [4:0]       addr,
  input  logic             cs_n,
  input  logic             wr_n,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [SW-1:0]    sound,
  output logic [8*NCH-1:0] ch_out
);

  logic [11:0]    tper_q [NCH];
  logic [4:0]     vol_q  [NCH];
  logic [4:0]     nper_q;
  logic [NCH-1:0] tdis_q;
  logic [NCH-1:0] ndis_q;
  logic [15:0]    eper_q;
  logic [3:0]     shape_q;
  logic [7:0]     dout_q;
  logic [7:0]     rd_data;
  logic           wr_en;

  assign wr_en = cen && !cs_n && !wr_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        tper_q[k] <= '0;
        vol_q[k]  <= '0;
      end
      nper_q  <= '0;
      tdis_q  <= '0;
      ndis_q  <= '0;
      eper_q  <= '0;
      shape_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NCH; k++) begin
        if (addr == ADDR_TONE_BASE + 5'(2 * k))     tper_q[k][7:0]  <= din;
        if (addr == ADDR_TONE_BASE + 5'(2 * k + 1)) tper_q[k][11:8] <= din[3:0];
        if (addr == ADDR_VOL_BASE + 5'(k))          vol_q[k]        <= din[4:0];
      end
      case (addr)
        RegNoisePer: nper_q        <= din[4:0];
        RegToneDis:  tdis_q        <= din[NCH-1:0];
        RegNoiseDis: ndis_q        <= din[NCH-1:0];
        RegEnvLo:    eper_q[7:0]   <= din;
        RegEnvHi:    eper_q[15:8]  <= din;
        RegEnvShape: shape_q       <= din[3:0];
        default: ;
      endcase
    end
  end

  // Absent channels and reserved addresses fall through to 0x00.
  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < NCH; k++) begin
      if (addr == ADDR_TONE_BASE + 5'(2 * k))     rd_data = tper_q[k][7:0];
      if (addr == ADDR_TONE_BASE + 5'(2 * k + 1)) rd_data = {4'h0, tper_q[k][11:8]};
      if (addr == ADDR_VOL_BASE + 5'(k))          rd_data = {3'h0, vol_q[k]};
    end
    case (addr)
      RegNoisePer: rd_data = {3'h0, nper_q};
      RegToneDis:  rd_data = 8'(tdis_q);
      RegNoiseDis: rd_data = 8'(ndis_q);
      RegEnvLo:    rd_data = eper_q[7:0];
      RegEnvHi:    rd_data = eper_q[15:8];
      RegEnvShape: rd_data = {4'h0, shape_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)            dout_q <= 8'h00;
    else if (cen && !cs_n) dout_q <= rd_data;
  end

  assign dout = dout_q;

  logic [3:0] pre_q;
  logic       tick_tone;
  logic       tick_env;

  always_ff @(posedge clk) begin
    if (!rst_n)   pre_q <= '0;
    else if (cen) pre_q <= pre_q + 4'd1;
  end

  assign tick_tone = cen && (pre_q[2:0] == 3'd7);
  assign tick_env  = cen && (pre_q == 4'hF);

  logic [NCH-1:0] tone;

  for (genvar k = 0; k < NCH; k++) begin : g_tone
    logic [11:0] cnt_q;
    logic [11:0] cnt_inc;
    logic [11:0] per_eff;
    logic        tone_q;
    logic        tog;

    assign per_eff = (tper_q[k] == 12'd0) ? 12'd1 : tper_q[k];
    assign cnt_inc = cnt_q + 12'd1;
    // >= lets a period shrunk below the running count toggle on the next tick.
    assign tog     = cnt_inc >= per_eff;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        tone_q <= 1'b0;
      end else if (tick_tone) begin
        cnt_q <= tog ? 12'd0 : cnt_inc;
        if (tog) tone_q <= ~tone_q;
      end
    end

    assign tone[k] = tone_q;
  end

  logic [4:0]  ncnt_q;
  logic [4:0]  ncnt_inc;
  logic [4:0]  nper_eff;
  logic        nclk_q;
  logic        ntog;
  logic [16:0] lfsr_q;
  logic        noise;

  assign nper_eff = (nper_q == 5'd0) ? 5'd1 : nper_q;
  assign ncnt_inc = ncnt_q + 5'd1;
  assign ntog     = ncnt_inc >= nper_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ncnt_q <= '0;
      nclk_q <= 1'b0;
      lfsr_q <= 17'd1;
    end else if (tick_tone) begin
      ncnt_q <= ntog ? 5'd0 : ncnt_inc;
      if (ntog) begin
        nclk_q <= ~nclk_q;
        if (!nclk_q) lfsr_q <= {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
      end
    end
  end

  assign noise = lfsr_q[0];

  logic [3:0] env;

  jt49_nch_eg u_eg (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .tick    (tick_env),
    .per     (eper_q),
    .shape   (shape_q),
    .restart (wr_en && (addr == RegEnvShape)),
    .env     (env)
  );

  // Three-stage pipeline: mix/level select, log-to-linear, sum.
  logic [NCH-1:0] mix_q;
  logic [4:0]     idx_q [NCH];
  logic [7:0]     lin_q [NCH];
  logic [SW-1:0]  sound_q;
  logic [SW-1:0]  sum_d;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NCH; k++) sum_d = sum_d + SW'(lin_q[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mix_q   <= '0;
      sound_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        idx_q[k] <= '0;
        lin_q[k] <= '0;
      end
    end else if (cen) begin
      for (int k = 0; k < NCH; k++) begin
        mix_q[k] <= (tone[k] | tdis_q[k]) & (noise | ndis_q[k]);
        idx_q[k] <= vol_q[k][4] ? {env, env[3]} : {vol_q[k][3:0], vol_q[k][3]};
        lin_q[k] <= mix_q[k] ? log2lin(idx_q[k]) : 8'd0;
      end
      sound_q <= sum_d;
    end
  end

  assign sound = sound_q;

`ifdef JT49_NCH_CHOUT_EN
  logic [8*NCH-1:0] chout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chout_q <= '0;
    end else if (cen) begin
      for (int k = 0; k < NCH; k++) chout_q[8*k +: 8] <= lin_q[k];
    end
  end

  assign ch_out = chout_q;
`else
  assign ch_out = '0;
`endif

endmodule

// File: tb/tb_jt49_nch.sv
// Scoreboard bench for jt49_nch: three instances (NCH=3, 8, 2) on a shared bus
// covering tone square, 8-channel sum, register masking, envelope and reset.
module tb_jt49_nch;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen   = 1'b1;
  logic [4:0] addr  = '0;
  logic [7:0] din   = '0;
  logic       wr_n  = 1'b1;
  logic       cs3_n = 1'b1;
  logic       cs8_n = 1'b1;
  logic       cs2_n = 1'b1;

  logic [7:0]  dout3, dout8, dout2;
  logic [9:0]  sound3;
  logic [23:0] ch3;
  logic [11:0] sound8;
  logic [63:0] ch8;
  logic [9:0]  sound2;
  logic [15:0] ch2;

  int n_checks = 0;
  int n_errors = 0;

  string       sb_tag [$];
  logic [63:0] sb_exp [$];

  logic [7:0] lin_tab [32] = '{
    8'd0,   8'd1,   8'd1,   8'd1,   8'd2,   8'd2,   8'd3,   8'd3,
    8'd4,   8'd5,   8'd6,   8'd7,   8'd9,   8'd11,  8'd13,  8'd15,
    8'd18,  8'd22,  8'd26,  8'd31,  8'd37,  8'd45,  8'd53,  8'd63,
    8'd75,  8'd90,  8'd107, 8'd127, 8'd151, 8'd180, 8'd214, 8'd255
  };

  always #5 clk = ~clk;

  jt49_nch #(.NCH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .addr(addr), .cs_n(cs3_n), .wr_n(wr_n),
    .din(din), .dout(dout3), .sound(sound3), .ch_out(ch3)
  );

  jt49_nch #(.NCH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .addr(addr), .cs_n(cs8_n), .wr_n(wr_n),
    .din(din), .dout(dout8), .sound(sound8), .ch_out(ch8)
  );

  jt49_nch #(.NCH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .addr(addr), .cs_n(cs2_n), .wr_n(wr_n),
    .din(din), .dout(dout2), .sound(sound2), .ch_out(ch2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    if (sb_exp.size() == 0) check("sb_empty", 64'(sb_exp.size()), 64'd1);
    else check(sb_tag.pop_front(), obs, sb_exp.pop_front());
  endtask

  function automatic logic [7:0] env_lin(input logic [3:0] l);
    logic [4:0] i;
    i = {l, l[3]};
    return lin_tab[i];
  endfunction

  task automatic set_cs(input int sel, input logic v);
    if (sel == 3) cs3_n = v;
    else if (sel == 8) cs8_n = v;
    else cs2_n = v;
  endtask

  function automatic logic [7:0] dout_of(input int sel);
    if (sel == 3) return dout3;
    if (sel == 8) return dout8;
    return dout2;
  endfunction

  task automatic wr(input int sel, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; wr_n = 1'b0; set_cs(sel, 1'b0);
    @(negedge clk);
    wr_n = 1'b1; set_cs(sel, 1'b1);
  endtask

  task automatic rd(input int sel, input logic [4:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    addr = a; wr_n = 1'b1; set_cs(sel, 1'b0);
    sb_push(tag, 64'(exp));
    @(negedge clk);
    set_cs(sel, 1'b1);
    sb_pop(64'(dout_of(sel)));
  endtask

  // Waits for sound3 to move; returns cycles waited, 0 on timeout.
  task automatic wait_change3(output int cycles);
    logic [9:0] prev;
    prev   = sound3;
    cycles = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (sound3 !== prev) begin
        cycles = c;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc;
    int  found;
    logic [9:0] prev;
    logic [63:0] ch_exp;

    repeat (3) @(negedge clk);
    check("rst_sound3", 64'(sound3), 64'd0);
    check("rst_dout3", 64'(dout3), 64'd0);
    check("rst_ch8", ch8, 64'd0);
    rst_n = 1'b1;

    // Register access on NCH=2: absent channel, reserved, masking.
    wr(2, 5'h04, 8'h55);
    rd(2, 5'h04, 8'h00, "rd2_absent_tone");
    wr(2, 5'h02, 8'h3A);
    rd(2, 5'h02, 8'h3A, "rd2_tone1_lo");
    wr(2, 5'h03, 8'hFF);
    rd(2, 5'h03, 8'h0F, "rd2_tone1_hi_mask");
    wr(2, 5'h12, 8'h1F);
    rd(2, 5'h12, 8'h00, "rd2_absent_vol");
    wr(2, 5'h11, 8'hFF);
    rd(2, 5'h11, 8'h1F, "rd2_vol1_mask");
    wr(2, 5'h1E, 8'hAA);
    rd(2, 5'h1E, 8'h00, "rd2_reserved");
    wr(2, 5'h1A, 8'hFF);
    rd(2, 5'h1A, 8'h03, "rd2_ndis_mask");

    // Eight channels at full scale: 8*255 without wrap.
    for (int k = 0; k < 8; k++) wr(8, 5'(5'h10 + k), 8'h0F);
    wr(8, 5'h19, 8'hFF);
    wr(8, 5'h1A, 8'hFF);
    repeat (5) @(negedge clk);
    check("nch8_sum_full", 64'(sound8), 64'd2040);
`ifdef JT49_NCH_CHOUT_EN
    check("nch8_chout", ch8, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("nch8_chout", ch8, 64'd0);
`endif
    wr(8, 5'h17, 8'h00);
    repeat (5) @(negedge clk);
    check("nch8_sum_ch7_off", 64'(sound8), 64'd1785);
`ifdef JT49_NCH_CHOUT_EN
    check("nch8_chout_ch7_off", ch8, 64'h00FF_FFFF_FFFF_FFFF);
`else
    check("nch8_chout_ch7_off", ch8, 64'd0);
`endif

    // Square wave on ch0 of NCH=3.
    wr(3, 5'h1A, 8'hFF);
    wr(3, 5'h19, 8'hFE);
    rd(3, 5'h19, 8'h06, "rd3_tdis_mask");
    wr(3, 5'h00, 8'h01);
    wr(3, 5'h10, 8'h0F);
    repeat (20) @(negedge clk);
    found = 0;
    prev  = sound3;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (prev == 10'd0 && sound3 == 10'd255) begin
        found = 1;
        break;
      end
      prev = sound3;
    end
    check("sq_rise_seen", 64'(found), 64'd1);
    for (int i = 0; i < 48; i++) begin
      ch_exp = ((i / 8) % 2 == 0) ? 64'd255 : 64'd0;
      sb_push("sq_sound", ch_exp);
      sb_pop(64'(sound3));
`ifdef JT49_NCH_CHOUT_EN
      sb_push("sq_chout", ch_exp);
`else
      sb_push("sq_chout", 64'd0);
`endif
      sb_pop(64'(ch3));
      @(negedge clk);
    end

    // Envelope attack-and-hold on ch0.
    wr(3, 5'h19, 8'hFF);
    wr(3, 5'h10, 8'h10);
    wr(3, 5'h1B, 8'h01);
    wr(3, 5'h1C, 8'h00);
    wr(3, 5'h1D, 8'h0D);
    repeat (3) @(negedge clk);
    sb_push("env_step0", 64'(env_lin(4'd0)));
    sb_pop(64'(sound3));
    for (int s = 1; s < 16; s++) begin
      wait_change3(cyc);
      check("env_step_seen", 64'(cyc != 0), 64'd1);
      sb_push("env_step", 64'(env_lin(4'(s))));
      sb_pop(64'(sound3));
      if (s >= 2) begin
        sb_push("env_step_interval", 64'd16);
        sb_pop(64'(cyc));
      end
    end
    repeat (48) @(negedge clk);
    check("env_hold", 64'(sound3), 64'd255);
`ifdef JT49_NCH_CHOUT_EN
    check("env_hold_chout", 64'(ch3), 64'd255);
`else
    check("env_hold_chout", 64'(ch3), 64'd0);
`endif
    rd(3, 5'h1B, 8'h01, "rd3_env_lo");
    wr(3, 5'h1D, 8'h0D);
    repeat (3) @(negedge clk);
    check("env_restart", 64'(sound3), 64'd0);
    wait_change3(cyc);
    check("env_restart_step1", 64'(sound3), 64'(env_lin(4'd1)));
    repeat (300) @(negedge clk);
    check("env_hold_again", 64'(sound3), 64'd255);
    rd(3, 5'h1D, 8'h0D, "rd3_shape");

    // One-cycle reset with cen low, mid-operation.
    cen   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_sound3", 64'(sound3), 64'd0);
    check("mrst_dout3", 64'(dout3), 64'd0);
    check("mrst_ch3", 64'(ch3), 64'd0);
    check("mrst_lfsr3", 64'(u_dut3.lfsr_q), 64'd1);
    check("mrst_sound8", 64'(sound8), 64'd0);
    check("mrst_ch8", ch8, 64'd0);
    rst_n = 1'b1;
    cen   = 1'b1;
    repeat (30) @(negedge clk);
    check("mrst_sound3_after", 64'(sound3), 64'd0);
    check("mrst_sound8_after", 64'(sound8), 64'd0);
    rd(3, 5'h10, 8'h00, "mrst_rd3_vol0");
    rd(3, 5'h1D, 8'h00, "mrst_rd3_shape");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
